// File: rtl/scc_wave_ram_arbiter.sv
// Arbitrates the single-port SCC wave RAM between CPU slot accesses and sound-engine sample fetches.
// Each access runs IDLE -> ACCESS -> WAIT x RAM_LAT (reads only) -> DONE, and a one-cycle ack is issued in DONE.
module scc_wave_ram_arbiter #(
  parameter int RAM_LAT  = 1,
  parameter int SCC_PLUS = 0,
  parameter int ARB_MODE = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_req,
  input  logic       cpu_rnw,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       snd_req,
  input  logic [2:0] snd_ch,
  input  logic [4:0] snd_idx,
  output logic       snd_ack,
  output logic [7:0] snd_rdata,
  output logic [7:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata
);
  localparam int          WAVE_BYTES = (SCC_PLUS != 0) ? 160 : 128;
  localparam logic [8:0]  WAVE_END   = WAVE_BYTES[8:0];
  localparam logic [1:0]  LAT_LOAD   = RAM_LAT[1:0];

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t     state, state_nxt;
  logic       grant_snd, last_snd, op_rnw, op_oor;
  logic [1:0] lat_cnt;
  logic       pick_snd, pick_rnw, pick_oor;
  logic [7:0] pick_addr;

  // Plain SCC has no separate ch4 wave: channel 4 plays channel 3's table.
  function automatic logic [7:0] snd_ram_addr(input logic [2:0] ch, input logic [4:0] idx);
    logic [2:0] eff_ch;
    eff_ch = (SCC_PLUS == 0 && ch == 3'd4) ? 3'd3 : ch;
    return {eff_ch, idx};
  endfunction

  always_comb begin
    if (cpu_req && snd_req)
      pick_snd = (ARB_MODE != 0) ? 1'b1 : !last_snd;
    else
      pick_snd = snd_req;
    pick_rnw  = pick_snd | cpu_rnw;
    pick_addr = pick_snd ? snd_ram_addr(snd_ch, snd_idx) : cpu_addr;
    pick_oor  = pick_snd ? (snd_ch > 3'd4) : ({1'b0, cpu_addr} >= WAVE_END);
  end

  always_comb begin
    state_nxt = state;
    cpu_ack   = 1'b0;
    snd_ack   = 1'b0;
    unique case (state)
      S_IDLE:   if (cpu_req || snd_req) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = (op_rnw && !op_oor) ? S_WAIT : S_DONE;
      S_WAIT:   if (lat_cnt == 2'd1) state_nxt = S_DONE;
      S_DONE: begin
        state_nxt = S_IDLE;
        cpu_ack   = !grant_snd;
        snd_ack   = grant_snd;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      grant_snd <= 1'b0;
      last_snd  <= 1'b0;
      op_rnw    <= 1'b0;
      op_oor    <= 1'b0;
      lat_cnt   <= 2'd0;
      ram_we    <= 1'b0;
      ram_addr  <= 8'h00;
      ram_wdata <= 8'h00;
      cpu_rdata <= 8'hFF;
      snd_rdata <= 8'h00;
    end else begin
      state  <= state_nxt;
      ram_we <= 1'b0;
      case (state)
        // Grant edge: RAM address/strobe are registered so they are live during ACCESS.
        S_IDLE: if (cpu_req || snd_req) begin
          grant_snd <= pick_snd;
          last_snd  <= pick_snd;
          op_rnw    <= pick_rnw;
          op_oor    <= pick_oor;
          if (!pick_oor) begin
            ram_addr <= pick_addr;
            ram_we   <= !pick_rnw;
            if (!pick_rnw) ram_wdata <= cpu_wdata;
          end
        end
        S_ACCESS: begin
          lat_cnt <= LAT_LOAD;
          if (op_oor && op_rnw) begin
            if (grant_snd) snd_rdata <= 8'h00;
            else           cpu_rdata <= 8'hFF;
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 2'd1;
          if (lat_cnt == 2'd1) begin
            if (grant_snd) snd_rdata <= ram_rdata;
            else           cpu_rdata <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_scc_wave_ram_arbiter.sv
// Directed bench for scc_wave_ram_arbiter: instance 0 is SCC/RAM_LAT=1/round-robin,
// instance 1 is SCC+/RAM_LAT=3/sound-priority; each has its own wave RAM model.
module tb_scc_wave_ram_arbiter;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req [2], cpu_rnw [2], cpu_ack [2];
  logic [7:0] cpu_addr [2], cpu_wdata [2], cpu_rdata [2];
  logic       snd_req [2], snd_ack [2];
  logic [2:0] snd_ch [2];
  logic [4:0] snd_idx [2];
  logic [7:0] snd_rdata [2];
  logic [7:0] ram_addr [2], ram_wdata [2], ram_rdata [2];
  logic       ram_we [2];
  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic       done;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [7:0] mem [256];
    logic [7:0] q [3];

    scc_wave_ram_arbiter #(.RAM_LAT(LAT), .SCC_PLUS(g), .ARB_MODE(g)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req[g]), .cpu_rnw(cpu_rnw[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
      .snd_req(snd_req[g]), .snd_ch(snd_ch[g]), .snd_idx(snd_idx[g]),
      .snd_ack(snd_ack[g]), .snd_rdata(snd_rdata[g]),
      .ram_addr(ram_addr[g]), .ram_we(ram_we[g]), .ram_wdata(ram_wdata[g]), .ram_rdata(ram_rdata[g])
    );

    always @(posedge clk) begin
      if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
      q[0] <= mem[ram_addr[g]];
      q[1] <= q[0];
      q[2] <= q[1];
    end
    assign ram_rdata[g] = q[LAT-1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // exp_lat < 0 means latency and first-cycle RAM checks are skipped (contended traffic).
  task automatic cpu_op(input int k, input logic rnw, input logic [7:0] addr, input logic [7:0] wdata,
                        input int exp_lat, input logic [7:0] exp_rd, input logic exp_ram);
    int n;
    logic [7:0] a0;
    @(posedge clk); #1;
    cpu_req[k] = 1'b1; cpu_rnw[k] = rnw; cpu_addr[k] = addr; cpu_wdata[k] = wdata;
    a0 = ram_addr[k];
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && exp_lat >= 0) begin
        chk("cpu_ram_we", ram_we[k], exp_ram && !rnw);
        chk("cpu_ram_addr", ram_addr[k], exp_ram ? addr : a0);
      end
    end while (!cpu_ack[k] && n < 40);
    cpu_req[k] = 1'b0;
    chk("cpu_ack", cpu_ack[k], 1);
    if (exp_lat >= 0) chk("cpu_lat", n, exp_lat);
    if (rnw) chk("cpu_rdata", cpu_rdata[k], exp_rd);
    @(posedge clk); #1;
    chk("cpu_ack_1cyc", cpu_ack[k], 0);
  endtask

  task automatic snd_op(input int k, input logic [2:0] ch, input logic [4:0] idx, input logic [7:0] exp_addr,
                        input int exp_lat, input logic [7:0] exp_rd, input logic exp_ram);
    int n;
    logic [7:0] a0;
    @(posedge clk); #1;
    snd_req[k] = 1'b1; snd_ch[k] = ch; snd_idx[k] = idx;
    a0 = ram_addr[k];
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && exp_lat >= 0) begin
        chk("snd_ram_we", ram_we[k], 0);
        chk("snd_ram_addr", ram_addr[k], exp_ram ? exp_addr : a0);
      end
    end while (!snd_ack[k] && n < 40);
    snd_req[k] = 1'b0;
    chk("snd_ack", snd_ack[k], 1);
    if (exp_lat >= 0) chk("snd_lat", n, exp_lat);
    chk("snd_rdata", snd_rdata[k], exp_rd);
    @(posedge clk); #1;
    chk("snd_ack_1cyc", snd_ack[k], 0);
  endtask

  task automatic tie(input int k, input logic [7:0] ca, input logic [7:0] cd, input logic [2:0] ch,
                     input logic [4:0] idx, input logic [7:0] sd, input int es, input int ec);
    int sc, cc;
    @(posedge clk); #1;
    cpu_req[k] = 1'b1; cpu_rnw[k] = 1'b1; cpu_addr[k] = ca;
    snd_req[k] = 1'b1; snd_ch[k] = ch; snd_idx[k] = idx;
    sc = -1; cc = -1;
    for (int n = 1; n <= 40 && (sc < 0 || cc < 0); n++) begin
      @(posedge clk); #1;
      if (snd_ack[k]) begin sc = n; snd_req[k] = 1'b0; chk("tie_snd_rdata", snd_rdata[k], sd); end
      if (cpu_ack[k]) begin cc = n; cpu_req[k] = 1'b0; chk("tie_cpu_rdata", cpu_rdata[k], cd); end
    end
    chk("tie_snd_cycle", sc, es);
    chk("tie_cpu_cycle", cc, ec);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input int k);
    chk("rst_cpu_ack", cpu_ack[k], 0);
    chk("rst_snd_ack", snd_ack[k], 0);
    chk("rst_ram_we", ram_we[k], 0);
    chk("rst_ram_addr", ram_addr[k], 0);
    chk("rst_ram_wdata", ram_wdata[k], 0);
    chk("rst_cpu_rdata", cpu_rdata[k], 8'hFF);
    chk("rst_snd_rdata", snd_rdata[k], 8'h00);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 0; cpu_rnw[k] = 0; cpu_addr[k] = 0; cpu_wdata[k] = 0;
      snd_req[k] = 0; snd_ch[k] = 0; snd_idx[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    reset_n = 1'b1;

    // Write then read back on SCC, RAM_LAT=1
    cpu_op(0, 1'b0, 8'h40, 8'h5A, 2, 8'h00, 1'b1);
    cpu_op(0, 1'b1, 8'h40, 8'h00, 3, 8'h5A, 1'b1);

    // Channel 4 aliasing
    cpu_op(0, 1'b0, 8'h60, 8'h33, 2, 8'h00, 1'b1);
    snd_op(0, 3'd4, 5'd0, 8'h60, 3, 8'h33, 1'b1);
    cpu_op(0, 1'b0, 8'h7F, 8'hC4, 2, 8'h00, 1'b1);
    snd_op(0, 3'd4, 5'd31, 8'h7F, 3, 8'hC4, 1'b1);
    cpu_op(1, 1'b0, 8'h80, 8'h77, 2, 8'h00, 1'b1);
    cpu_op(1, 1'b0, 8'h60, 8'h33, 2, 8'h00, 1'b1);
    snd_op(1, 3'd4, 5'd0, 8'h80, 5, 8'h77, 1'b1);
    snd_op(1, 3'd3, 5'd0, 8'h60, 5, 8'h33, 1'b1);

    // Out-of-range accesses
    cpu_op(1, 1'b1, 8'hA0, 8'h00, 2, 8'hFF, 1'b0);
    snd_op(1, 3'd5, 5'd0, 8'h00, 2, 8'h00, 1'b0);
    cpu_op(0, 1'b0, 8'h80, 8'hEE, 2, 8'h00, 1'b0);
    cpu_op(0, 1'b1, 8'h90, 8'h00, 2, 8'hFF, 1'b0);
    cpu_op(1, 1'b1, 8'h80, 8'h00, 5, 8'h77, 1'b1);
    snd_op(1, 3'd3, 5'd0, 8'h60, 5, 8'h33, 1'b1);

    // Reset during the WAIT phase of a CPU read
    @(posedge clk); #1;
    cpu_req[1] = 1'b1; cpu_rnw[1] = 1'b1; cpu_addr[1] = 8'h60;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_no_ack", cpu_ack[1], 0);
    reset_n = 1'b0;
    cpu_req[1] = 1'b0;
    @(posedge clk); #1;
    chk_reset(1);
    chk_reset(0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rst_after_no_ack", cpu_ack[1], 0);
    end

    // Ties: round-robin from reset, then after a sound grant; sound priority on instance 1
    tie(0, 8'h40, 8'h5A, 3'd2, 5'd0, 8'h5A, 3, 7);
    snd_op(0, 3'd2, 5'd0, 8'h40, 3, 8'h5A, 1'b1);
    tie(0, 8'h40, 8'h5A, 3'd2, 5'd0, 8'h5A, 7, 3);
    cpu_op(1, 1'b1, 8'h80, 8'h00, 5, 8'h77, 1'b1);
    tie(1, 8'h80, 8'h77, 3'd3, 5'd0, 8'h33, 5, 11);

    // Full SCC+ sweep, readback under random sound traffic
    for (int i = 0; i < 160; i++) cpu_op(1, 1'b0, 8'(i), pat(i), 2, 8'h00, 1'b1);
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 160; i++) cpu_op(1, 1'b1, 8'(i), 8'h00, -1, pat(i), 1'b1);
        done = 1'b1;
      end
      begin
        int ch, idx;
        while (!done) begin
          repeat ($urandom_range(8, 15)) @(posedge clk);
          if (!done) begin
            ch  = $urandom_range(0, 4);
            idx = $urandom_range(0, 31);
            snd_op(1, 3'(ch), 5'(idx), 8'h00, -1, pat(ch * 32 + idx), 1'b1);
          end
        end
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
